// File: rtl/addsub_serial_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int SLICE_W = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_ctrl_if.sv
// Operand/result handshake bundle between an operand source and the sequencer.
interface addsub_serial_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_carry, out_ovf, out_zero
  );

endinterface

// File: rtl/addsub_slice4.sv
// Combinational 4-bit add/subtract slice: {cout,s} = a + (b ^ {4{m}}) + cin.
module addsub_slice4
  import addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               m,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] sum;

  assign sum       = {1'b0, a} + {1'b0, b ^ {SLICE_W{m}}} + {{SLICE_W{1'b0}}, cin};
  assign {cout, s} = sum;

endmodule

// File: rtl/addsub_serial_ctrl.sv
// Runs WIDTH-bit add/subtract one nibble per clock through a single shared slice,
// LSB nibble first, with valid/ready handshakes on operands and result.
module addsub_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  addsub_serial_ctrl_if.slave  bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("addsub_serial_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   b_reg, b_next;
  logic               m_reg, m_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               carry_reg, carry_next;
  logic [WIDTH-1:0]   result_reg, result_next;
  logic               ovf_reg, ovf_next;
  logic               zero_reg, zero_next;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_s;
  logic               slice_cout;

  assign slice_a = a_reg[idx_reg*SLICE_W +: SLICE_W];
  assign slice_b = b_reg[idx_reg*SLICE_W +: SLICE_W];

  addsub_slice4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .m    (m_reg),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      m_reg      <= MODE_ADD;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      zero_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      m_reg      <= m_next;
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      zero_reg   <= zero_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    m_next      = m_reg;
    idx_next    = idx_reg;
    carry_next  = carry_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    zero_next   = zero_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_next      = bus.in_a;
          b_next      = bus.in_b;
          m_next      = bus.in_mode;
          idx_next    = '0;
          carry_next  = bus.in_mode;
          result_next = '0;
          ovf_next    = 1'b0;
          zero_next   = 1'b0;
          state_next  = ST_RUN;
        end
      end
      ST_RUN: begin
        result_next[idx_reg*SLICE_W +: SLICE_W] = slice_s;
        carry_next = slice_cout;
        // Flags are frozen from the completed result on the final nibble pass.
        if (idx_reg == IDX_LAST) begin
          ovf_next   = (a_reg[WIDTH-1] == (b_reg[WIDTH-1] ^ m_reg)) &&
                       (result_next[WIDTH-1] != a_reg[WIDTH-1]);
          zero_next  = ~|result_next;
          state_next = ST_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready   = (state_reg == ST_IDLE);
  assign bus.out_valid  = (state_reg == ST_DONE);
  assign bus.out_result = result_reg;
  assign bus.out_carry  = carry_reg;
  assign bus.out_ovf    = ovf_reg;
  assign bus.out_zero   = zero_reg;

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Self-checking bench for addsub_serial_ctrl (WIDTH=16): directed cases,
// backpressure, reset abort and randomized back-to-back ops vs an arithmetic model.
module tb_addsub_serial_ctrl;
  import addsub_pkg::*;

  localparam int W   = 16;
  localparam int NSL = W / 4;
  localparam int NRAND = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  addsub_serial_ctrl_if #(.WIDTH(W)) bus();

  addsub_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                                output logic [W-1:0] r, output logic c, output logic v,
                                output logic z);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'(signed'(a));
    longint sb = longint'(signed'(b));
    longint u;
    longint s;
    if (m == MODE_SUB) begin
      u = ua - ub;
      s = sa - sb;
      c = (ua >= ub);
    end else begin
      u = ua + ub;
      s = sa + sb;
      c = (u >= 65536);
    end
    r = u[W-1:0];
    v = (s > 32767) || (s < -32768);
    z = (r == '0);
  endfunction

  // Present an operand pair, wait for acceptance, then scramble the inputs.
  task automatic present(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    int n = 0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = m;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = W'($urandom);
    bus.in_b     = W'($urandom);
    bus.in_mode  = 1'($urandom);
    check("busy_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  // Wait for the result, check it, hold it under backpressure, then hand it off.
  task automatic collect(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input int bp, input bit early_ready, input bit nxt,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic nm);
    logic [W-1:0] er;
    logic ec, ev, ez;
    int lat = 0;
    model(a, b, m, er, ec, ev, ez);
    bus.out_ready = early_ready && (bp == 0);
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(NSL));
    if (!bus.out_valid) begin
      bus.out_ready = 1'b0;
      return;
    end
    $display("op a=%h b=%h m=%0d -> r=%h c=%0d v=%0d z=%0d",
             a, b, m, bus.out_result, bus.out_carry, bus.out_ovf, bus.out_zero);
    check("result", 32'(bus.out_result), 32'(er));
    check("carry", 32'(bus.out_carry), 32'(ec));
    check("ovf", 32'(bus.out_ovf), 32'(ev));
    check("zero", 32'(bus.out_zero), 32'(ez));
    bus.out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      if (nxt) begin
        bus.in_a     = na;
        bus.in_b     = nb;
        bus.in_mode  = nm;
        bus.in_valid = 1'b1;
      end
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_result", 32'(bus.out_result), 32'(er));
      check("hold_carry", 32'(bus.out_carry), 32'(ec));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    if (nxt) begin
      bus.in_a     = na;
      bus.in_b     = nb;
      bus.in_mode  = nm;
      bus.in_valid = 1'b1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("released", 32'(bus.out_valid), 32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd1);
  endtask

  logic [W-1:0] ra[NRAND+1];
  logic [W-1:0] rb[NRAND+1];
  logic         rm[NRAND+1];

  initial begin
    bit seen_valid;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", 32'(bus.out_result), 32'd0);
    check("rst_carry", 32'(bus.out_carry), 32'd0);
    check("rst_ovf", 32'(bus.out_ovf), 32'd0);
    check("rst_zero", 32'(bus.out_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed arithmetic cases
    present(16'h1234, 16'h0FFF, MODE_ADD);
    collect(16'h1234, 16'h0FFF, MODE_ADD, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    present(16'hFFFF, 16'h0001, MODE_ADD);
    collect(16'hFFFF, 16'h0001, MODE_ADD, 0, 1'b1, 1'b0, '0, '0, 1'b0);
    present(16'h0005, 16'h0007, MODE_SUB);
    collect(16'h0005, 16'h0007, MODE_SUB, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    present(16'h8000, 16'h0001, MODE_SUB);
    collect(16'h8000, 16'h0001, MODE_SUB, 0, 1'b0, 1'b0, '0, '0, 1'b0);
    present(16'h7FFF, 16'h0001, MODE_ADD);
    collect(16'h7FFF, 16'h0001, MODE_ADD, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Backpressure with a second operand pair held during DONE
    present(16'h00A0, 16'h0050, MODE_SUB);
    collect(16'h00A0, 16'h0050, MODE_SUB, 5, 1'b0, 1'b1, 16'h0102, 16'h0304, MODE_ADD);
    present(16'h0102, 16'h0304, MODE_ADD);
    collect(16'h0102, 16'h0304, MODE_ADD, 0, 1'b0, 1'b0, '0, '0, 1'b0);

    // Reset abort while the third nibble is pending
    present(16'h1111, 16'h2222, MODE_ADD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_result", 32'(bus.out_result), 32'd0);
    check("abort_carry", 32'(bus.out_carry), 32'd0);
    check("abort_flags", {30'd0, bus.out_ovf, bus.out_zero}, 32'd0);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen_valid = 1'b1;
    end
    check("abort_no_valid", 32'(seen_valid), 32'd0);

    // Randomized back-to-back operations
    for (int i = 0; i <= NRAND; i++) begin
      ra[i] = W'($urandom);
      rb[i] = W'($urandom);
      rm[i] = 1'($urandom);
      if (i % 50 == 0) rb[i] = ra[i];
    end
    for (int i = 0; i < NRAND; i++) begin
      present(ra[i], rb[i], rm[i]);
      collect(ra[i], rb[i], rm[i], int'($urandom_range(0, 2)), 1'($urandom), 1'b1,
              ra[i+1], rb[i+1], rm[i+1]);
    end
    bus.in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
